// File: rtl/latex_rx_pkg.sv
// Shared constants and state encoding for the LaTeX line receiver.
`default_nettype none

package latex_rx_pkg;

  localparam int          DEPTH    = 32;
  localparam logic [7:0]  CRC_POLY = 8'h07;
  localparam logic [7:0]  CRC_INIT = 8'h00;
  localparam logic [7:0]  NUL_CHAR = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_DONE    = 2'd3
  } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/latex_line_receiver_crc8_step.sv
// One byte of a non-reflected, MSB-first CRC-8 update (purely combinational).
`default_nettype none

module crc8_step #(
  parameter logic [7:0] CRC_POLY = 8'h07
) (
  input  logic [7:0] crc_in,
  input  logic [7:0] data_byte,
  output logic [7:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ data_byte;
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[7] ? ((crc_out << 1) ^ CRC_POLY) : (crc_out << 1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/latex_line_receiver.sv
// Collects NUL-terminated ASCII frames into a buffer with a running CRC-8,
// holding each completed frame until the consumer acknowledges it.
`default_nettype none

module latex_line_receiver #(
  parameter int         DEPTH    = latex_rx_pkg::DEPTH,
  parameter logic [7:0] CRC_POLY = latex_rx_pkg::CRC_POLY,
  parameter logic [7:0] CRC_INIT = latex_rx_pkg::CRC_INIT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  output logic                       frame_valid,
  output logic [$clog2(DEPTH):0]     frame_len,
  output logic [7:0]                 frame_crc,
  output logic                       frame_ovf,
  input  logic                       frame_ack,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [7:0]                 rd_data
);

  import latex_rx_pkg::*;

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LEN_W  = ADDR_W + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);

  rx_state_e          state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [7:0]         crc_q, crc_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic [7:0]         buf_mem [DEPTH];

  logic               xfer;
  logic               is_nul;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [7:0]         crc_next;

  crc8_step #(
    .CRC_POLY (CRC_POLY)
  ) u_crc8_step (
    .crc_in    (crc_q),
    .data_byte (in_data),
    .crc_out   (crc_next)
  );

  assign in_ready = (state_q != ST_DONE);
  assign xfer     = in_valid && in_ready;
  assign is_nul   = (in_data == NUL_CHAR);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    crc_d   = crc_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    wr_addr = len_q[ADDR_W-1:0];

    case (state_q)
      ST_IDLE: begin
        // NULs arriving between frames are padding and are dropped here
        if (xfer && !is_nul) begin
          wr_en   = 1'b1;
          len_d   = LEN_W'(1);
          crc_d   = crc_next;
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (xfer) begin
          if (is_nul) begin
            state_d = ST_DONE;
          end else if (len_q < LEN_MAX) begin
            wr_en = 1'b1;
            len_d = len_q + LEN_W'(1);
            crc_d = crc_next;
          end else begin
            ovf_d   = 1'b1;
            state_d = ST_DISCARD;
          end
        end
      end
      ST_DISCARD: begin
        if (xfer && is_nul) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (frame_ack) begin
          len_d   = '0;
          crc_d   = CRC_INIT;
          ovf_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reads beyond the stored length return zero, which also hides stale bytes
  always_comb begin
    rd_data_d = 8'h00;
    if ({1'b0, rd_addr} < len_q) begin
      rd_data_d = buf_mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      crc_q     <= CRC_INIT;
      ovf_q     <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      crc_q     <= crc_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      buf_mem[wr_addr] <= in_data;
    end
  end

  assign frame_valid = (state_q == ST_DONE);
  assign frame_len   = len_q;
  assign frame_crc   = crc_q;
  assign frame_ovf   = ovf_q;
  assign rd_data     = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_latex_line_receiver.sv
// Directed self-checking bench for latex_line_receiver.
`default_nettype none

module tb_latex_line_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       frame_valid;
  logic [5:0] frame_len;
  logic [7:0] frame_crc;
  logic       frame_ovf;
  logic       frame_ack;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  latex_line_receiver u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .frame_valid (frame_valid),
    .frame_len   (frame_len),
    .frame_crc   (frame_crc),
    .frame_ovf   (frame_ovf),
    .frame_ack   (frame_ack),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC-8 (poly 0x07, MSB-first) used to derive expected CRCs
  function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int k = 0; k < 8; k++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input int max_gap);
    for (int i = 0; i < s.len(); i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
      send(s[i]);
    end
    if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
    send(8'h00);
  endtask

  task automatic read_chk(input logic [4:0] a, input logic [7:0] exp, input string tag);
    rd_addr = a;
    tick();
    check(tag, rd_data, exp);
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  task automatic check_digits(input string tag);
    string d;
    d = "123456789";
    check({tag, "_valid"}, frame_valid, 1);
    check({tag, "_len"}, frame_len, 9);
    check({tag, "_crc"}, frame_crc, 8'hF4);
    check({tag, "_ovf"}, frame_ovf, 0);
    for (int i = 0; i < 9; i++) read_chk(5'(i), d[i], $sformatf("%s_rd%0d", tag, i));
    read_chk(5'd9, 8'h00, {tag, "_rd9"});
  endtask

  initial begin
    logic [7:0] exp_crc;
    logic [5:0] held_len;
    logic [7:0] held_crc;
    int         ready_cnt;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; frame_ack = 1'b0; rd_addr = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_valid", frame_valid, 0);
    check("rst_len", frame_len, 0);
    check("rst_crc", frame_crc, 8'h00);
    check("rst_ovf", frame_ovf, 0);
    check("rst_rd", rd_data, 8'h00);
    check("rst_ready", in_ready, 1);

    // Continuous "123456789"
    send_str("123456789", 0);
    check_digits("digits");

    // Held frame must ignore traffic while DONE
    held_len = frame_len;
    held_crc = frame_crc;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("done_ready%0d", i), in_ready, 0);
      send("x");
    end
    check("done_len_hold", frame_len, held_len);
    check("done_crc_hold", frame_crc, held_crc);
    check("done_valid_hold", frame_valid, 1);
    ack();
    check("ack_valid", frame_valid, 0);
    check("ack_len", frame_len, 0);
    check("ack_crc", frame_crc, 8'h00);
    check("ack_ready", in_ready, 1);
    ack();
    check("idle_ack_valid", frame_valid, 0);
    check("idle_ack_len", frame_len, 0);
    check("idle_ack_ready", in_ready, 1);

    // Leading NUL padding
    repeat (3) send(8'h00);
    check("pad_valid", frame_valid, 0);
    check("pad_len", frame_len, 0);
    send_str("s", 0);
    check("s_valid", frame_valid, 1);
    check("s_len", frame_len, 1);
    check("s_crc", frame_crc, crc_ref(8'h00, 8'h73));
    read_chk(5'd0, 8'h73, "s_rd0");
    read_chk(5'd1, 8'h00, "s_rd1");
    ack();

    // Overflow: 40 'a' chars, only 32 kept
    ready_cnt = 0;
    exp_crc   = 8'h00;
    for (int i = 0; i < 32; i++) exp_crc = crc_ref(exp_crc, "a");
    for (int i = 0; i < 40; i++) begin
      if (in_ready) ready_cnt++;
      send("a");
      if (i == 31) check("ovf_running_len", frame_len, 32);
      if (i == 32) check("ovf_running_flag", frame_ovf, 1);
    end
    check("ovf_ready_cnt", ready_cnt, 40);
    check("ovf_running_crc", frame_crc, exp_crc);
    send(8'h00);
    check("ovf_valid", frame_valid, 1);
    check("ovf_len", frame_len, 32);
    check("ovf_flag", frame_ovf, 1);
    check("ovf_crc", frame_crc, exp_crc);
    read_chk(5'd31, "a", "ovf_rd31");
    ack();
    check("ovf_clr", frame_ovf, 0);

    // Reset in the middle of a frame
    send("w"); send("x"); send("y"); send("z");
    check("mid_len", frame_len, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_len", frame_len, 0);
    check("mrst_crc", frame_crc, 8'h00);
    check("mrst_valid", frame_valid, 0);
    send_str("ab", 0);
    check("ab_len", frame_len, 2);
    check("ab_crc", frame_crc, crc_ref(crc_ref(8'h00, "a"), "b"));
    read_chk(5'd0, "a", "ab_rd0");
    read_chk(5'd1, "b", "ab_rd1");
    read_chk(5'd2, 8'h00, "ab_rd2");
    ack();

    // Random gaps give the same result as the continuous stream
    send_str("123456789", 3);
    check_digits("gaps");
    ack();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
